// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM states,
// the redirect PC reset value and the sequential-PC helper.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Fall-through PC; wraps modulo 2^32 by construction.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= '0;
        end else if (inc && (value_reg != {W{1'b1}})) begin
            value_reg <= value_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves control-flow instructions in EX, raises a registered redirect
// to fetch on mispredict and holds flush for FLUSH_CYCLES cycles.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_cond_br,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_tgt,
    input  logic             taken_br,
    input  logic [31:0]      br_tgt_pc,
    input  logic [31:0]      jalr_tgt_pc,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             ex_stall,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_reg;
    logic [3:0]  drain_cnt_reg;

    logic        is_ctrl;
    logic        actual_taken;
    logic [31:0] actual_tgt;
    logic        misaligned;
    logic        mispredict;
    logic        resolve;
    logic        count_inc;

    always_comb begin
        is_ctrl      = ex_is_cond_br | ex_is_jal | ex_is_jalr;
        actual_taken = ex_is_cond_br ? taken_br : (ex_is_jal | ex_is_jalr);
        if (ex_is_jalr) begin
            actual_tgt = {jalr_tgt_pc[31:1], 1'b0};
        end else if (actual_taken) begin
            actual_tgt = br_tgt_pc;
        end else begin
            actual_tgt = seq_pc(ex_pc);
        end
        misaligned = actual_taken & actual_tgt[1];
        mispredict = is_ctrl & ((actual_taken != ex_pred_taken) |
                                (actual_taken & (ex_pred_tgt != actual_tgt)));
        resolve    = ex_valid & (state_reg == IDLE);
        // A misaligned target raises an exception instead of a redirect.
        count_inc  = resolve & mispredict & ~misaligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            drain_cnt_reg  <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            flush          <= 1'b0;
            ex_stall       <= 1'b0;
            misalign_exc   <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (resolve) begin
                        if (misaligned) begin
                            misalign_exc <= 1'b1;
                        end else if (mispredict) begin
                            state_reg      <= REQ;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= actual_tgt;
                            flush          <= 1'b1;
                            ex_stall       <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        ex_stall       <= 1'b0;
                        if (FLUSH_CYCLES == 1) begin
                            state_reg <= IDLE;
                            flush     <= 1'b0;
                        end else begin
                            state_reg     <= DRAIN;
                            drain_cnt_reg <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    // The handshake cycle already counted as one flush cycle.
                    if (drain_cnt_reg <= 4'd1) begin
                        state_reg     <= IDLE;
                        flush         <= 1'b0;
                        drain_cnt_reg <= '0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (count_inc),
        .value (mispredict_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a driver issues directed and
// random instructions, a monitor checks redirects/exceptions against a model.
module tb_branch_redirect_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_cond_br, ex_is_jal, ex_is_jalr;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_tgt;
    logic        taken_br;
    logic [31:0] br_tgt_pc, jalr_tgt_pc;
    logic        redirect_ready;

    logic        redirect_valid, flush, ex_stall, misalign_exc;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    logic        redirect_valid_2, flush_2, ex_stall_2, misalign_exc_2;
    logic [31:0] redirect_pc_2;
    logic [1:0]  mispredict_cnt_2;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_cond_br(ex_is_cond_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt),
        .taken_br(taken_br), .br_tgt_pc(br_tgt_pc), .jalr_tgt_pc(jalr_tgt_pc),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .ex_stall(ex_stall),
        .misalign_exc(misalign_exc), .mispredict_cnt(mispredict_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_is_cond_br(ex_is_cond_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt),
        .taken_br(taken_br), .br_tgt_pc(br_tgt_pc), .jalr_tgt_pc(jalr_tgt_pc),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid_2),
        .redirect_pc(redirect_pc_2), .flush(flush_2), .ex_stall(ex_stall_2),
        .misalign_exc(misalign_exc_2), .mispredict_cnt(mispredict_cnt_2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input int w);
        int top;
        top = (1 << w) - 1;
        return (c > top) ? top : c;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_cond, is_jal, is_jalr, pred_taken, taken_br;
        logic [31:0] pc, pred_tgt, br_tgt, jalr_tgt;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
    } exp_t;

    exp_t redir_q[$];
    int   mis_q[$];
    int   model_cnt = 0;

    // Outcome: 0 = nothing, 1 = redirect, 2 = misalign exception.
    function automatic int model(input instr_t i, output bit tk, output logic [31:0] tgt);
        bit ctrl;
        ctrl = i.is_cond || i.is_jal || i.is_jalr;
        tk   = i.is_cond ? i.taken_br : (i.is_jal || i.is_jalr);
        if (i.is_jalr)  tgt = i.jalr_tgt & 32'hFFFF_FFFE;
        else if (tk)    tgt = i.br_tgt;
        else            tgt = i.pc + 32'd4;
        if (!ctrl) return 0;
        if (tk && tgt[1]) return 2;
        if ((tk != i.pred_taken) || (tk && (tgt != i.pred_tgt))) return 1;
        return 0;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      i;
        bit          tk;
        logic [31:0] t;
        int          k;
        k          = $urandom_range(0, 3);
        i.is_cond  = (k == 1);
        i.is_jal   = (k == 2);
        i.is_jalr  = (k == 3);
        i.pc       = $urandom & ~32'h3;
        if ($urandom_range(0, 15) == 0) i.pc = 32'hFFFF_FFFC;
        i.taken_br = 1'($urandom_range(0, 1));
        i.br_tgt   = $urandom & ~32'h3;
        if ($urandom_range(0, 7) == 0) i.br_tgt[1] = 1'b1;
        i.jalr_tgt = $urandom;
        if ($urandom_range(0, 3) != 0) i.jalr_tgt[1] = 1'b0;
        i.pred_taken = 1'($urandom_range(0, 1));
        i.pred_tgt   = $urandom & ~32'h3;
        if ($urandom_range(0, 1) == 1) begin
            void'(model(i, tk, t));
            i.pred_taken = tk;
            i.pred_tgt   = t;
        end
        return i;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic apply(input instr_t i);
        ex_valid      = 1'b1;
        ex_pc         = i.pc;
        ex_is_cond_br = i.is_cond;
        ex_is_jal     = i.is_jal;
        ex_is_jalr    = i.is_jalr;
        ex_pred_taken = i.pred_taken;
        ex_pred_tgt   = i.pred_tgt;
        taken_br      = i.taken_br;
        br_tgt_pc     = i.br_tgt;
        jalr_tgt_pc   = i.jalr_tgt;
    endtask

    // A taken cond branch predicted not-taken: would redirect if accepted.
    task automatic drive_garbage(input bit force_valid);
        ex_valid      = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
        ex_pc         = $urandom & ~32'h3;
        ex_is_cond_br = 1'b1;
        ex_is_jal     = 1'b0;
        ex_is_jalr    = 1'b0;
        ex_pred_taken = 1'b0;
        ex_pred_tgt   = 32'h0;
        taken_br      = 1'b1;
        br_tgt_pc     = $urandom & ~32'h3;
        jalr_tgt_pc   = 32'h0;
    endtask

    // Entered one step after the mispredict edge; returns with DUT back in IDLE.
    task automatic wait_redirect_done(input int hold_low);
        int cyc;
        cyc = 0;
        forever begin
            if (cyc < hold_low) begin
                redirect_ready = 1'b0;
                drive_garbage(1'b1);
            end else begin
                redirect_ready = 1'($urandom_range(0, 1));
                drive_garbage(1'b0);
            end
            @(negedge clk);
            if (redirect_valid && redirect_ready) break;
            cyc++;
            if (cyc > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout: actual=no handshake required=handshake within 100 cycles");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        repeat (FC - 1) begin
            drive_garbage(1'b0);
            redirect_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
    endtask

    task automatic issue(input instr_t i, input int hold_low);
        logic [31:0] t;
        bit          tk;
        int          r;
        r = model(i, tk, t);
        if (r == 1) begin
            model_cnt++;
            redir_q.push_back('{pc: t, cnt: model_cnt});
        end else if (r == 2) begin
            mis_q.push_back(model_cnt);
        end
        apply(i);
        if (r == 1 && hold_low > 0) redirect_ready = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (r == 1) begin
            wait_redirect_done(hold_low);
        end else begin
            @(negedge clk);
            check("no_redirect", {31'd0, redirect_valid}, 32'd0);
            @(posedge clk); #1;
        end
        $display("tx kind=%0d pc=%08h tgt=%08h cnt=%0d", r, i.pc, t, model_cnt);
    endtask

    // ---------------- monitor ----------------
    logic [31:0] prev_pc;
    bit          prev_wait;
    bit          in_drain;
    int          drain_run;
    exp_t        mon_e;
    int          mon_m;

    always @(negedge clk) begin
        if (rst) begin
            prev_wait <= 1'b0;
            in_drain  <= 1'b0;
            drain_run <= 0;
        end else begin
            if (redirect_valid) begin
                check("req_flush_stall", {30'd0, flush, ex_stall}, 32'd3);
                if (prev_wait) check("pc_stable", redirect_pc, prev_pc);
            end
            prev_wait <= redirect_valid && !redirect_ready;
            prev_pc   <= redirect_pc;
            if (redirect_valid && redirect_ready) begin
                if (redir_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: actual pc=%0h required=no redirect", redirect_pc);
                end else begin
                    mon_e = redir_q.pop_front();
                    check("redirect_pc", redirect_pc, mon_e.pc);
                    check("redirect_pc_2", redirect_pc_2, mon_e.pc);
                    check("cnt16", {16'd0, mispredict_cnt}, 32'(sat(mon_e.cnt, 16)));
                    check("cnt2", {30'd0, mispredict_cnt_2}, 32'(sat(mon_e.cnt, 2)));
                end
                in_drain  <= 1'b1;
                drain_run <= 0;
            end else if (in_drain) begin
                if (flush && !redirect_valid) begin
                    drain_run <= drain_run + 1;
                end else begin
                    check("drain_len", 32'(drain_run), 32'(FC - 1));
                    in_drain <= 1'b0;
                end
            end
            if (misalign_exc) begin
                if (mis_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_misalign: actual=1 required=0");
                end else begin
                    mon_m = mis_q.pop_front();
                    check("misalign_cnt", {16'd0, mispredict_cnt}, 32'(sat(mon_m, 16)));
                    check("misalign_no_redirect", {31'd0, redirect_valid}, 32'd0);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    instr_t ins;

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_pc = '0; ex_is_cond_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        ex_pred_taken = 1'b0; ex_pred_tgt = '0; taken_br = 1'b0;
        br_tgt_pc = '0; jalr_tgt_pc = '0; redirect_ready = 1'b0;

        @(negedge clk);
        check("reset_outputs", {26'd0, redirect_valid, flush, ex_stall, misalign_exc, 2'b00},
              32'd0);
        check("reset_pc", redirect_pc, 32'd0);
        check("reset_cnt", {14'd0, mispredict_cnt, mispredict_cnt_2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // beq taken to 0x100, predicted not-taken, fetch ready immediately.
        ins = '{is_cond: 1, is_jal: 0, is_jalr: 0, pred_taken: 0, taken_br: 1,
                pc: 32'h40, pred_tgt: 32'h0, br_tgt: 32'h100, jalr_tgt: 32'h0};
        model_cnt++;
        redir_q.push_back('{pc: 32'h100, cnt: model_cnt});
        apply(ins);
        redirect_ready = 1'b1;
        @(negedge clk);
        check("beq_n_idle", {31'd0, redirect_valid}, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("beq_n1_vfs", {29'd0, redirect_valid, flush, ex_stall}, 32'd7);
        check("beq_n1_pc", redirect_pc, 32'h100);
        check("beq_n1_cnt", {16'd0, mispredict_cnt}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("beq_n2_vfs", {29'd0, redirect_valid, flush, ex_stall}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("beq_n3_vfs", {29'd0, redirect_valid, flush, ex_stall}, 32'd0);
        @(posedge clk); #1;
        $display("tx beq directed pc=00000040 tgt=00000100 cnt=%0d", model_cnt);

        // bne not-taken at the top of the address space, predicted taken.
        ins = '{is_cond: 1, is_jal: 0, is_jalr: 0, pred_taken: 1, taken_br: 0,
                pc: 32'hFFFF_FFFC, pred_tgt: 32'h80, br_tgt: 32'h80, jalr_tgt: 32'h0};
        issue(ins, 0);

        // jalr: LSB cleared matches prediction; then a bit-1 misaligned target.
        redirect_ready = 1'b1;
        ins = '{is_cond: 0, is_jal: 0, is_jalr: 1, pred_taken: 1, taken_br: 0,
                pc: 32'h1000, pred_tgt: 32'h200, br_tgt: 32'h0, jalr_tgt: 32'h201};
        issue(ins, 0);
        ins.jalr_tgt = 32'h202;
        ins.pred_tgt = 32'h202;
        issue(ins, 0);

        // Fetch not ready for 3 cycles while ex_valid mispredicts keep arriving.
        ins = '{is_cond: 0, is_jal: 1, is_jalr: 0, pred_taken: 0, taken_br: 0,
                pc: 32'h2000, pred_tgt: 32'h0, br_tgt: 32'h3000, jalr_tgt: 32'h0};
        issue(ins, 3);

        for (int n = 0; n < 250; n++) begin
            ins = rand_instr();
            issue(ins, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an outstanding redirect.
        ins = '{is_cond: 1, is_jal: 0, is_jalr: 0, pred_taken: 0, taken_br: 1,
                pc: 32'h500, pred_tgt: 32'h0, br_tgt: 32'h700, jalr_tgt: 32'h0};
        apply(ins);
        redirect_ready = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {28'd0, redirect_valid, flush, ex_stall, misalign_exc}, 32'd0);
        check("rst_async_pc", redirect_pc, 32'd0);
        check("rst_async_cnt", {14'd0, mispredict_cnt, mispredict_cnt_2}, 32'd0);
        model_cnt = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        redirect_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_reissue", {31'd0, redirect_valid}, 32'd0);
        end
        @(posedge clk); #1;
        $display("tx reset mid-REQ abandoned redirect");

        for (int n = 0; n < 40; n++) begin
            ins = rand_instr();
            issue(ins, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("redir_q_empty", 32'(redir_q.size()), 32'd0);
        check("mis_q_empty", 32'(mis_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
